mof_sweep_ctrl: RTL

MOF_SWEEP_CTRL -- requirements
Module: mof_sweep_ctrl

---
 rtl/mof_sweep_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mof_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// mof_sweep_ctrl
//
// Exhaustive sweep controller for a majority-of-five unit. On a start
// request it drives each 5-bit vector 0..31 in ascending order onto sw_out.
// Each vector is held for STEP_CYCLES clock cycles. On the last cycle of
// each hold, the unit's led_in response is sampled. The number of '1'
// responses is accumulated into ones_count.
//
// Optional feature (macro MOF_SWEEP_CHECK_EN):
//   When defined, every sampled response is compared against a golden
//   majority value (popcount(vec) >= 3). Disagreements are counted in
//   mismatch_count. When undefined, no golden logic exists and
//   mismatch_count is tied to 0. The port list is the same in both builds.
//
// Parameters:
//   STEP_CYCLES    : cycles each vector is held on sw_out (1..255)
//
// Ports:
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous active-high reset
//   start          : sweep request, only looked at while idle
//   sw_out[4:0]    : vector driven to the majority unit's sw input
//   led_in         : majority unit's led output fed back to us
//   busy           : high while vectors are being applied
//   done           : one-cycle pulse when a sweep finishes
//   ones_count[5:0]: number of led_in=1 samples in the last sweep (0..32)
//   mismatch_count[5:0]: golden-model disagreements in the last sweep
// ---------------------------------------------------------------------------
module mof_sweep_ctrl #(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [4:0] sw_out,
    input  logic       led_in,
    output logic       busy,
    output logic       done,
    output logic [5:0] ones_count,
    output logic [5:0] mismatch_count
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(STEP_CYCLES - 1);
    localparam logic [4:0] VEC_LAST  = 5'd31;

    state_t     state;
    state_t     state_next;
    logic [4:0] vec;
    logic [7:0] hold;
    logic       sample;
    logic       accept;

    // A start request only counts while idle. Starts seen during APPLY or
    // DONE are dropped, so they cannot restart a sweep or touch the counters.
    assign accept = (state == IDLE) && start;

    // State register. Reset wins over everything else, including a start
    // that arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. The outputs depend only on the state
    // (plus the vector register while applying). Because of that, clearing
    // the state on reset also clears sw_out, busy and done.
    // The sample strobe marks the final cycle of each vector's hold window.
    always_comb begin
        state_next = state;
        sw_out     = '0;
        busy       = 1'b0;
        done       = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy   = 1'b1;
                sw_out = vec;
                if (hold == HOLD_LAST) begin
                    sample = 1'b1;
                    if (vec == VEC_LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: vector register, hold counter and the ones counter.
    // The vector stops at 31; the FSM leaves APPLY on that sample, so it
    // never wraps. ones_count keeps its final value while idle. It is only
    // cleared by the next accepted start or by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec        <= '0;
            hold       <= '0;
            ones_count <= '0;
        end else if (accept) begin
            vec        <= '0;
            hold       <= '0;
            ones_count <= '0;
        end else if (sample) begin
            hold       <= '0;
            ones_count <= ones_count + {5'd0, led_in};
            if (vec != VEC_LAST) begin
                vec <= vec + 5'd1;
            end
        end else if (state == APPLY) begin
            hold <= hold + 8'd1;
        end
    end

`ifdef MOF_SWEEP_CHECK_EN

    logic [5:0] mismatch_q;
    logic       golden;

    // Number of ones in a 5-bit vector.
    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'd0, v[i]};
        end
        return n;
    endfunction

    // Golden majority result for the vector currently being applied.
    assign golden = (popcount5(vec) >= 3'd3);

    // Mismatch counter. It follows the same clear and hold rules as
    // ones_count. It only advances on sample cycles where the unit
    // disagrees with the golden value.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= '0;
        end else if (accept) begin
            mismatch_q <= '0;
        end else if (sample && (led_in != golden)) begin
            mismatch_q <= mismatch_q + 6'd1;
        end
    end

    assign mismatch_count = mismatch_q;

`else

    // Checking is compiled out, so the count is constant zero.
    assign mismatch_count = '0;

`endif

endmodule
